rgb_timing_ctrl: RTL and testbench

Mode controller for the RGB/HDMI timing generator. Accepts resolution-change requests (480p/720p/1080p), waits for a frame boundary, and halts the generator. It then sequences the pixel-clock reconfiguration, loads the new timing parameter set and re-enables the generator after a settle interval. It runs on the system clock, beside the clock-reconfiguration block and the timing generator.

---
 rtl/rgb_timing_pkg.sv | 53 +++++
 rtl/rgb_vsync_sync.sv | 19 +
 rtl/rgb_timing_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rgb_timing_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_timing_pkg.sv
// Shared mode/state types and the fixed video timing tables for rgb_timing_ctrl.
package rgb_timing_pkg;

  typedef enum logic [1:0] {
    MODE_480P  = 2'd0,
    MODE_720P  = 2'd1,
    MODE_1080P = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef struct packed {
    logic [11:0] res_x;
    logic [11:0] res_y;
    logic [11:0] hfront;
    logic [11:0] hsync_len;
    logic [11:0] hback;
    logic [11:0] vfront;
    logic [11:0] vsync_len;
    logic [11:0] vback;
  } timing_t;

  localparam timing_t TIMING_480P = '{res_x: 12'd640, res_y: 12'd480,
    hfront: 12'd16, hsync_len: 12'd96, hback: 12'd48,
    vfront: 12'd10, vsync_len: 12'd2, vback: 12'd33};

  localparam timing_t TIMING_720P = '{res_x: 12'd1280, res_y: 12'd720,
    hfront: 12'd110, hsync_len: 12'd40, hback: 12'd220,
    vfront: 12'd5, vsync_len: 12'd5, vback: 12'd20};

  localparam timing_t TIMING_1080P = '{res_x: 12'd1920, res_y: 12'd1080,
    hfront: 12'd88, hsync_len: 12'd44, hback: 12'd148,
    vfront: 12'd4, vsync_len: 12'd5, vback: 12'd36};

  typedef enum logic [2:0] {
    ST_CLK_REQ,
    ST_CLK_WAIT,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_WAIT_VS
  } state_e;

  // The reserved code never reaches LOAD; it falls back to 480p only for completeness.
  function automatic timing_t mode_timing(input logic [1:0] mode);
    case (mode)
      MODE_720P:  return TIMING_720P;
      MODE_1080P: return TIMING_1080P;
      default:    return TIMING_480P;
    endcase
  endfunction

endpackage

// File: rtl/rgb_vsync_sync.sv
// Brings the pixel-domain vsync into the system clock and flags its rising edge.
module rgb_vsync_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_rise
);

  // [0],[1] form the synchronizer; [2] is the edge-detect history.
  logic [2:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], i_vsync};
  end

  assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rgb_timing_ctrl.sv
// Resolution-change sequencer for the RGB/HDMI timing generator.
// Optional clock-config timeout/retry: define RGB_TIMING_CTRL_TIMEOUT_EN.
module rgb_timing_ctrl
  import rgb_timing_pkg::*;
#(
  parameter int unsigned P_DEFAULT_MODE   = 0,
  parameter int unsigned P_SETTLE_CYCLES  = 1024,
  parameter int unsigned P_TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic [1:0]  i_req_mode,
  output logic        o_req_ready,
  input  logic        i_vsync,
  output logic        o_clk_cfg_req,
  output logic [1:0]  o_clk_mode,
  input  logic        i_clk_cfg_done,
  output logic        o_tg_en,
  output logic [1:0]  o_mode,
  output logic [11:0] o_res_x,
  output logic [11:0] o_res_y,
  output logic [11:0] o_hfront,
  output logic [11:0] o_hsync_len,
  output logic [11:0] o_hback,
  output logic [11:0] o_vfront,
  output logic [11:0] o_vsync_len,
  output logic [11:0] o_vback,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [1:0]  DEF_MODE    = 2'(P_DEFAULT_MODE);
  localparam logic [19:0] SETTLE_LAST = 20'(P_SETTLE_CYCLES);

  if (P_SETTLE_CYCLES > 32'h000F_FFFF || P_TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("rgb_timing_ctrl: P_SETTLE_CYCLES exceeds 20 bits or P_TIMEOUT_CYCLES is zero");
  end

  state_e      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  mode_q, mode_d;
  timing_t     tim_q, tim_d;
  logic [1:0]  clk_mode_q, clk_mode_d;
  logic        cfg_req_q, cfg_req_d;
  logic        tg_en_q, tg_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [19:0] settle_q, settle_d;
  logic        vs_rise;
  logic        accept;

`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(P_TIMEOUT_CYCLES - 1);
  logic [31:0] to_q, to_d;
`endif

  rgb_vsync_sync u_vsync_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vsync (i_vsync),
    .o_rise  (vs_rise)
  );

  assign o_req_ready = (state_q == ST_RUN);
  assign accept      = i_req_valid && (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    mode_d     = mode_q;
    tim_d      = tim_q;
    clk_mode_d = clk_mode_q;
    cfg_req_d  = 1'b0;
    tg_en_d    = tg_en_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    settle_d   = settle_q;
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      ST_CLK_REQ: begin
        cfg_req_d  = 1'b1;
        clk_mode_d = pend_q;
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
        to_d       = '0;
`endif
        state_d    = ST_CLK_WAIT;
      end
      ST_CLK_WAIT: begin
        if (i_clk_cfg_done) state_d = ST_LOAD;
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_CLK_REQ;
        end
        else to_d = to_q + 32'd1;
`endif
      end
      ST_LOAD: begin
        mode_d   = pend_q;
        tim_d    = mode_timing(pend_q);
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          tg_en_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 20'd1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (i_req_mode == MODE_RSVD)   err_d = 1'b1;
          else if (i_req_mode == mode_q) done_d = 1'b1;
          else begin
            pend_d  = i_req_mode;
            state_d = ST_WAIT_VS;
          end
        end
      end
      ST_WAIT_VS: begin
        if (vs_rise) begin
          tg_en_d = 1'b0;
          state_d = ST_CLK_REQ;
        end
      end
      default: state_d = ST_CLK_REQ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_CLK_REQ;
      pend_q     <= DEF_MODE;
      mode_q     <= DEF_MODE;
      tim_q      <= mode_timing(DEF_MODE);
      clk_mode_q <= DEF_MODE;
      cfg_req_q  <= 1'b0;
      tg_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      settle_q   <= '0;
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      tim_q      <= tim_d;
      clk_mode_q <= clk_mode_d;
      cfg_req_q  <= cfg_req_d;
      tg_en_q    <= tg_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign o_clk_cfg_req = cfg_req_q;
  assign o_clk_mode    = clk_mode_q;
  assign o_tg_en       = tg_en_q;
  assign o_mode        = mode_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_res_x       = tim_q.res_x;
  assign o_res_y       = tim_q.res_y;
  assign o_hfront      = tim_q.hfront;
  assign o_hsync_len   = tim_q.hsync_len;
  assign o_hback       = tim_q.hback;
  assign o_vfront      = tim_q.vfront;
  assign o_vsync_len   = tim_q.vsync_len;
  assign o_vback       = tim_q.vback;

endmodule

// File: tb/tb_rgb_timing_ctrl.sv
// Directed bench for rgb_timing_ctrl: table of RUN-state requests plus power-up/reset/timeout sequences.
module tb_rgb_timing_ctrl;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned TIMEOUT = 100;

  // Field order [0..7]: res_x, res_y, hfront, hsync, hback, vfront, vsync, vback.
  localparam logic [7:0][11:0] T480  = {12'd33, 12'd2, 12'd10, 12'd48,  12'd96, 12'd16,  12'd480,  12'd640};
  localparam logic [7:0][11:0] T720  = {12'd20, 12'd5, 12'd5,  12'd220, 12'd40, 12'd110, 12'd720,  12'd1280};
  localparam logic [7:0][11:0] T1080 = {12'd36, 12'd5, 12'd4,  12'd148, 12'd44, 12'd88,  12'd1080, 12'd1920};

  localparam logic [1:0] K_ERR = 2'd0, K_SAME = 2'd1, K_CHANGE = 2'd2;

  typedef struct packed {
    logic [1:0]       mode;
    logic [1:0]       kind;
    logic [1:0]       exp_mode;
    logic [7:0][11:0] exp_p;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, req_valid, vsync, cfg_done;
  logic [1:0] req_mode;
  logic req_ready, cfg_req, tg_en, done, err;
  logic [1:0] clk_mode, mode;
  logic [11:0] res_x, res_y, hfront, hsync_len, hback, vfront, vsync_len, vback;

  int n_chk  = 0;
  int n_fail = 0;
  string fname [8] = '{"res_x", "res_y", "hfront", "hsync_len", "hback", "vfront", "vsync_len", "vback"};
  vec_t vecs [8];

  always #5 clk = ~clk;

  rgb_timing_ctrl #(
    .P_DEFAULT_MODE  (0),
    .P_SETTLE_CYCLES (SETTLE),
    .P_TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_mode(req_mode),
    .o_req_ready(req_ready), .i_vsync(vsync), .o_clk_cfg_req(cfg_req), .o_clk_mode(clk_mode),
    .i_clk_cfg_done(cfg_done), .o_tg_en(tg_en), .o_mode(mode),
    .o_res_x(res_x), .o_res_y(res_y), .o_hfront(hfront), .o_hsync_len(hsync_len),
    .o_hback(hback), .o_vfront(vfront), .o_vsync_len(vsync_len), .o_vback(vback),
    .o_done(done), .o_err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_params(input string tag, input logic [7:0][11:0] exp);
    logic [7:0][11:0] act;
    act = {vback, vsync_len, vfront, hback, hsync_len, hfront, res_y, res_x};
    for (int i = 0; i < 8; i++) chk({tag, ".", fname[i]}, 32'(act[i]), 32'(exp[i]));
  endtask

  // Entered while the controller is in CLK_WAIT.
  task automatic finish_load(input string tag, input logic [7:0][11:0] old_p,
                             input logic [7:0][11:0] new_p, input logic [1:0] new_mode);
    int k;
    cfg_done = 1'b1;
    tick();
    chk({tag, ".tg_en_in_load"}, 32'(tg_en), 0);
    chk_params({tag, ".before_load"}, old_p);
    tick();
    cfg_done = 1'b0;
    chk_params({tag, ".after_load"}, new_p);
    chk({tag, ".mode"}, 32'(mode), 32'(new_mode));
    chk({tag, ".tg_en_settle"}, 32'(tg_en), 0);
    k = 0;
    while (k < int'(SETTLE) + 20 && !tg_en) begin
      tick();
      k++;
    end
    chk({tag, ".tg_en_rise_delay"}, 32'(k), 32'(SETTLE + 1));
    chk({tag, ".done_with_tg_en"}, 32'(done), 1);
    chk({tag, ".ready_in_run"}, 32'(req_ready), 1);
    tick();
    chk({tag, ".done_one_cycle"}, 32'(done), 0);
  endtask

  task automatic wait_cfg_req(input string tag, input logic [1:0] exp_mode);
    int k;
    k = 0;
    while (k < 10 && !cfg_req) begin
      tick();
      k++;
    end
    chk({tag, ".cfg_req_seen"}, 32'(cfg_req), 1);
    chk({tag, ".clk_mode"}, 32'(clk_mode), 32'(exp_mode));
  endtask

  task automatic vsync_to_halt(input string tag);
    int k;
    vsync = 1'b1;
    k = 0;
    while (k < 10 && tg_en) begin
      tick();
      k++;
    end
    chk({tag, ".tg_en_fall_3to4"}, 32'(k >= 3 && k <= 4), 1);
    vsync = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] m);
    chk("req.ready_before", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_mode  = m;
    tick();
    req_valid = 1'b0;
    req_mode  = 2'd0;
  endtask

  initial begin
    logic [7:0][11:0] cur_p;
    int n_req, n_err, n_hi;

    vecs[0] = '{mode: 2'd3, kind: K_ERR,    exp_mode: 2'd0, exp_p: T480};
    vecs[1] = '{mode: 2'd0, kind: K_SAME,   exp_mode: 2'd0, exp_p: T480};
    vecs[2] = '{mode: 2'd1, kind: K_CHANGE, exp_mode: 2'd1, exp_p: T720};
    vecs[3] = '{mode: 2'd1, kind: K_SAME,   exp_mode: 2'd1, exp_p: T720};
    vecs[4] = '{mode: 2'd3, kind: K_ERR,    exp_mode: 2'd1, exp_p: T720};
    vecs[5] = '{mode: 2'd2, kind: K_CHANGE, exp_mode: 2'd2, exp_p: T1080};
    vecs[6] = '{mode: 2'd2, kind: K_SAME,   exp_mode: 2'd2, exp_p: T1080};
    vecs[7] = '{mode: 2'd0, kind: K_CHANGE, exp_mode: 2'd0, exp_p: T480};

    rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'd0; vsync = 1'b0; cfg_done = 1'b0;
    tick(); tick();
    chk("rst.tg_en", 32'(tg_en), 0);
    chk("rst.ready", 32'(req_ready), 0);
    chk("rst.cfg_req", 32'(cfg_req), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.mode", 32'(mode), 0);
    chk("rst.clk_mode", 32'(clk_mode), 0);
    chk_params("rst", T480);

    // Power-up: config done arrives 50 cycles after reset release.
    rst_n = 1'b1;
    n_req = 0; n_err = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cfg_req) begin
        n_req++;
        chk("pwr.clk_mode", 32'(clk_mode), 0);
      end
      if (err) n_err++;
    end
    chk("pwr.cfg_req_count", 32'(n_req), 1);
    chk("pwr.err_count", 32'(n_err), 0);
    finish_load("pwr", T480, T480, 2'd0);
    cur_p = T480;

    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].mode);
      case (vecs[v].kind)
        K_ERR: begin
          chk("err.err_pulse", 32'(err), 1);
          chk("err.done", 32'(done), 0);
          chk("err.tg_en", 32'(tg_en), 1);
          chk("err.ready", 32'(req_ready), 1);
          chk("err.mode", 32'(mode), 32'(vecs[v].exp_mode));
          chk_params("err", vecs[v].exp_p);
          tick();
          chk("err.one_cycle", 32'(err), 0);
        end
        K_SAME: begin
          chk("same.done_pulse", 32'(done), 1);
          chk("same.err", 32'(err), 0);
          chk("same.cfg_req", 32'(cfg_req), 0);
          chk("same.ready", 32'(req_ready), 1);
          chk_params("same", vecs[v].exp_p);
          tick();
          chk("same.one_cycle", 32'(done), 0);
          chk("same.no_cfg_req", 32'(cfg_req), 0);
        end
        default: begin
          chk("chg.ready_low", 32'(req_ready), 0);
          chk("chg.no_done", 32'(done | err), 0);
          n_req = 0;
          for (int i = 0; i < 200; i++) begin
            tick();
            if (cfg_req) n_req++;
          end
          chk("chg.no_cfg_req_before_vsync", 32'(n_req), 0);
          chk("chg.tg_en_held", 32'(tg_en), 1);
          vsync_to_halt("chg");
          wait_cfg_req("chg", vecs[v].exp_mode);
          chk_params("chg.halted", cur_p);
          finish_load("chg", cur_p, vecs[v].exp_p, vecs[v].exp_mode);
          cur_p = vecs[v].exp_p;
        end
      endcase
    end

    // Reset during CLK_WAIT of a 480p -> 1080p change.
    do_req(2'd2);
    tick();
    vsync_to_halt("rstmid");
    wait_cfg_req("rstmid", 2'd2);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid.clk_mode", 32'(clk_mode), 0);
    chk("rstmid.mode", 32'(mode), 0);
    chk("rstmid.tg_en", 32'(tg_en), 0);
    chk("rstmid.cfg_req", 32'(cfg_req), 0);
    chk("rstmid.ready", 32'(req_ready), 0);
    chk_params("rstmid", T480);
    tick(); tick();
    rst_n = 1'b1;

    // Config done withheld: retries only exist with the timeout feature.
    n_req = 0; n_err = 0; n_hi = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (cfg_req) begin
        n_req++;
        chk("to.clk_mode", 32'(clk_mode), 0);
      end
      if (err) n_err++;
      if (tg_en) n_hi++;
    end
`ifdef RGB_TIMING_CTRL_TIMEOUT_EN
    chk("to.cfg_req_count", 32'(n_req), 3);
    chk("to.err_count", 32'(n_err), 2);
`else
    chk("to.cfg_req_count", 32'(n_req), 1);
    chk("to.err_count", 32'(n_err), 0);
`endif
    chk("to.tg_en_low", 32'(n_hi), 0);
    finish_load("rerun", T480, T480, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
